// File: rtl/truth_table_preimage_enum.sv
// -----------------------------------------------------------------------------
// truth_table_preimage_enum
//
// Enumerates the preimage of one output code of a fixed 4-in/3-out priority
// truth table:
//     out1 = i1&i2;  out2 = i1&~i2&i3;  out3 = i1&~i2&~i3&i4
// For each request it walks all 16 input vectors {in1,in2,in3,in4} in
// ascending order. Every vector that maps to the requested code
// {out1,out2,out3} is streamed out over a valid/ready port. A one-cycle
// done pulse ends the scan, and match_count then holds the number of vectors
// that were streamed.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    request strobe, accepted while req_ready is high
//   req_ready    high only while idle
//   req_code     requested {out1,out2,out3}, sampled on the request handshake
//   vec_valid    vec_data carries a matching input vector
//   vec_ready    downstream accepts the vector (ignored unless emitting)
//   vec_data     matching {in1,in2,in3,in4}
//   vec_last     high with vec_valid on the final matching vector
//   done         one-cycle pulse when the scan has finished
//   match_count  number of vectors emitted, held until the next request
//   code_err     req_code was neither 000 nor one-hot, held until next request
// -----------------------------------------------------------------------------
module truth_table_preimage_enum #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] req_code,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [IN_W-1:0]  vec_data,
    output logic             vec_last,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             code_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Forward truth table: maps {in1,in2,in3,in4} to {out1,out2,out3}.
    function automatic logic [OUT_W-1:0] table_code(input logic [IN_W-1:0] v);
        logic [OUT_W-1:0] c;
        c[2] = v[3] & v[2];
        c[1] = v[3] & ~v[2] & v[1];
        c[0] = v[3] & ~v[2] & ~v[1] & v[0];
        return c;
    endfunction

    // A code is legal when it is all-zero or has exactly one bit set.
    function automatic logic code_illegal(input logic [OUT_W-1:0] c);
        return (c & (c - 3'd1)) != 3'd0;
    endfunction

    // True when no vector strictly above idx maps to code, i.e. the vector at
    // idx is the final one of this preimage.
    function automatic logic none_after(input logic [IN_W-1:0] idx,
                                        input logic [OUT_W-1:0] code);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if ((j > int'(idx)) && (table_code(4'(j)) == code)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return !hit;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [IN_W-1:0]  cnt_r;
    logic [OUT_W-1:0] code_r;
    logic [CNT_W-1:0] match_count_r;
    logic             code_err_r;

    logic             match_s;
    logic             cnt_end_s;
    logic             last_s;
    logic             req_hs_s;
    logic             vec_hs_s;

    // Decode of the current scan position against the latched code.
    always_comb begin
        match_s   = (table_code(cnt_r) == code_r);
        cnt_end_s = (cnt_r == 4'hF);
        last_s    = none_after(cnt_r, code_r);
        req_hs_s  = (state_r == ST_IDLE) && req_valid;
        vec_hs_s  = (state_r == ST_EMIT) && vec_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = ST_SCAN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (match_s) begin
                    next_state_s = ST_EMIT;
                end else if (cnt_end_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SCAN;
                end
            end
            ST_EMIT: begin
                if (vec_ready) begin
                    // vec_last already covers cnt=15; both ends finish the scan.
                    if (cnt_end_s || last_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_SCAN;
                    end
                end else begin
                    next_state_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Scan counter, latched request code, match counter and code error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r         <= 4'd0;
            code_r        <= 3'd0;
            match_count_r <= 5'd0;
            code_err_r    <= 1'b0;
        end else if (req_hs_s) begin
            cnt_r         <= 4'd0;
            code_r        <= req_code;
            match_count_r <= 5'd0;
            code_err_r    <= code_illegal(req_code);
        end else if ((state_r == ST_SCAN) && !match_s && !cnt_end_s) begin
            cnt_r <= cnt_r + 4'd1;
        end else if (vec_hs_s) begin
            match_count_r <= match_count_r + 5'd1;
            if (!(cnt_end_s || last_s)) begin
                cnt_r <= cnt_r + 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Outputs decoded straight from flops so reset clears them immediately.
    always_comb begin
        req_ready   = (state_r == ST_IDLE);
        vec_valid   = (state_r == ST_EMIT);
        vec_data    = (state_r == ST_EMIT) ? cnt_r : 4'd0;
        vec_last    = (state_r == ST_EMIT) && last_s;
        done        = (state_r == ST_DONE);
        match_count = match_count_r;
        code_err    = code_err_r;
    end

endmodule
